// File: rtl/stim_sig_harness.sv
// LFSR-driven stimulus source and MISR response compactor for exercising a DUT by signature.
// Optional STIM_TRACE_EN adds a valid/ready trace port that can stall each capture.
module stim_sig_harness #(
    parameter int IN_W    = 256,
    parameter int OUT_W   = 360,
    parameter int NUM_VEC = 20,
    parameter int SETTLE  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [31:0]      seed_i,
    input  logic [31:0]      exp_sig_i,
    output logic [IN_W-1:0]  stim_o,
    input  logic [OUT_W-1:0] dut_y_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [31:0]      sig_o,
    output logic [15:0]      vec_cnt_o
`ifdef STIM_TRACE_EN
    ,
    output logic             trace_valid_o,
    input  logic             trace_ready_i,
    output logic [OUT_W-1:0] trace_data_o
`endif
);

    localparam int W  = (IN_W + 31) / 32;
    localparam int SW = W * 32;
    localparam int NS = (OUT_W + 31) / 32;
    localparam int OP = NS * 32;

    localparam logic [31:0] LFSR_POLY   = 32'h80200003;
    localparam logic [31:0] MISR_POLY   = 32'h04C11DB7;
    localparam logic [31:0] ZERO_LAST   = 32'(SETTLE);
    localparam logic [31:0] FILL_LAST   = 32'(W - 1);
    localparam logic [31:0] SETTLE_LAST = (SETTLE > 0) ? 32'(SETTLE - 1) : 32'd0;
    localparam logic [15:0] NUM_VEC16   = 16'(NUM_VEC);

    if (NUM_VEC < 1 || NUM_VEC > 65535) begin : g_num_vec_chk
        $error("stim_sig_harness: NUM_VEC must be in 1..65535");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_ZERO, S_FILL, S_APPLY, S_SETTLE, S_CAPTURE, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     lfsr_q, lfsr_d;
    logic [31:0]     cnt_q, cnt_d;
    logic [SW-1:0]   shadow_q, shadow_d;
    logic [IN_W-1:0] stim_q, stim_d;
    logic [31:0]     sig_q, sig_d;
    logic [15:0]     vec_cnt_q, vec_cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;

    logic [31:0]     lfsr_nxt;
    logic [SW-1:0]   shadow_fill;
    logic [OP-1:0]   y_pad;
    logic [31:0]     fold;
    logic [31:0]     sig_nxt;
    logic [15:0]     vec_inc;
    logic            cap_fire;

    assign lfsr_nxt = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_POLY : 32'h0);

    // Newest LFSR word enters at the bottom, so the first word of a vector ends up most significant.
    if (W > 1) begin : g_shadow_wide
        assign shadow_fill = {shadow_q[SW-33:0], lfsr_nxt};
    end else begin : g_shadow_narrow
        assign shadow_fill = lfsr_nxt;
    end

    always_comb begin
        y_pad = '0;
        y_pad[OUT_W-1:0] = dut_y_i;
        fold = 32'h0;
        for (int i = 0; i < NS; i++) begin
            fold = fold ^ y_pad[i*32 +: 32];
        end
    end

    assign sig_nxt = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? MISR_POLY : 32'h0) ^ fold;
    assign vec_inc = (vec_cnt_q == 16'hFFFF) ? vec_cnt_q : vec_cnt_q + 16'd1;

`ifdef STIM_TRACE_EN
    assign cap_fire      = trace_ready_i;
    assign trace_valid_o = (state_q == S_CAPTURE);
    assign trace_data_o  = dut_y_i;
`else
    assign cap_fire = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        cnt_d     = cnt_q;
        shadow_d  = shadow_q;
        stim_d    = stim_q;
        sig_d     = sig_q;
        vec_cnt_d = vec_cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pass_d    = pass_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    lfsr_d    = (seed_i == 32'h0) ? 32'h1 : seed_i;
                    sig_d     = 32'hFFFFFFFF;
                    vec_cnt_d = 16'h0;
                    pass_d    = 1'b0;
                    stim_d    = '0;
                    busy_d    = 1'b1;
                    cnt_d     = 32'h0;
                    state_d   = S_ZERO;
                end
            end
            S_ZERO: begin
                if (cnt_q == ZERO_LAST) begin
                    cnt_d   = 32'h0;
                    state_d = S_FILL;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_FILL: begin
                lfsr_d   = lfsr_nxt;
                shadow_d = shadow_fill;
                if (cnt_q == FILL_LAST) begin
                    cnt_d   = 32'h0;
                    state_d = S_APPLY;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_APPLY: begin
                stim_d  = shadow_q[IN_W-1:0];
                cnt_d   = 32'h0;
                state_d = (SETTLE == 0) ? S_CAPTURE : S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = 32'h0;
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_CAPTURE: begin
                if (cap_fire) begin
                    sig_d     = sig_nxt;
                    vec_cnt_d = vec_inc;
                    if (vec_inc == NUM_VEC16) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            S_DONE: begin
                pass_d  = (sig_q == exp_sig_i);
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            lfsr_q    <= 32'h1;
            cnt_q     <= 32'h0;
            shadow_q  <= '0;
            stim_q    <= '0;
            sig_q     <= 32'h0;
            vec_cnt_q <= 16'h0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            stim_q    <= stim_d;
            sig_q     <= sig_d;
            vec_cnt_q <= vec_cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
        end
    end

    assign stim_o    = stim_q;
    assign sig_o     = sig_q;
    assign vec_cnt_o = vec_cnt_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign pass_o    = pass_q;

endmodule
